// File: rtl/fetch_queue_pkg.sv
// Core-shared fetch types: datapath width, NOP encoding and the
// fetch-entry bundle reused by decode and the IF/ID path.
package fetch_queue_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            taken;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: in-order circular buffer with
// single-cycle flush, no bypass and registered-state-only readiness.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [XLEN-1:0]         in_inst,
   input  logic                    in_taken,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [XLEN-1:0]         out_pc,
   output logic [XLEN-1:0]         out_inst,
   output logic                    out_taken,
   input  logic                    out_ready,
   input  logic                    flush,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   fetch_entry_t  w_head;

   assign in_ready  = (r_count != FULL);
   assign out_valid = (r_count != '0);

   // flush wins: an entry offered alongside it is dropped
   assign w_push = in_valid && in_ready && !flush;
   assign w_pop  = out_valid && out_ready && !flush;

   assign w_head    = r_mem[r_rd];
   assign out_pc    = out_valid ? w_head.pc    : '0;
   assign out_inst  = out_valid ? w_head.inst  : NOP;
   assign out_taken = out_valid ? w_head.taken : 1'b0;
   assign count     = r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // storage needs no reset; out_valid masks stale slots
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr] <= '{pc: in_pc, inst: in_inst, taken: in_taken};
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOPV = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        in_taken = 1'b0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_taken;
   logic [2:0]  count;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_taken  (in_taken),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .out_taken (out_taken),
      .out_ready (out_ready),
      .flush     (flush),
      .count     (count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        taken;
   } ent_t;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        rdy;
      logic        fl;
      int          cnt;
      logic        ov;
      logic        ir;
      logic [31:0] opc;
      logic [31:0] oinst;
   } vec_t;

   ent_t q[$];
   vec_t tbl[9];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return (pc * 32'd2654435761) | 32'h3;
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = mk_inst(pc);
      in_taken  = pc[2];
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic check_model();
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einst;
      logic        etk;
      ev    = (q.size() != 0);
      epc   = ev ? q[0].pc : 32'h0;
      einst = ev ? q[0].inst : NOPV;
      etk   = ev ? q[0].taken : 1'b0;
      chk("model_count", 32'(count), 32'(q.size()));
      chk("model_out_valid", 32'(out_valid), 32'(ev));
      chk("model_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("model_out_pc", out_pc, epc);
      chk("model_out_inst", out_inst, einst);
      chk("model_out_taken", 32'(out_taken), 32'(etk));
   endtask

   task automatic tick();
      bit   do_push;
      bit   do_pop;
      ent_t e;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      e.pc    = in_pc;
      e.inst  = in_inst;
      e.taken = in_taken;
      if (flush) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [31:0] pc,
                       input logic rdy, input logic fl);
      drive(v, pc, rdy, fl);
      check_model();
      tick();
   endtask

   initial begin
      // fill, refused fifth push, in-order drain
      tbl[0] = '{1, 32'h00, 0, 0, 1, 1, 1, 32'h00, mk_inst(32'h00)};
      tbl[1] = '{1, 32'h04, 0, 0, 2, 1, 1, 32'h00, mk_inst(32'h00)};
      tbl[2] = '{1, 32'h08, 0, 0, 3, 1, 1, 32'h00, mk_inst(32'h00)};
      tbl[3] = '{1, 32'h0C, 0, 0, 4, 1, 0, 32'h00, mk_inst(32'h00)};
      tbl[4] = '{1, 32'h10, 0, 0, 4, 1, 0, 32'h00, mk_inst(32'h00)};
      tbl[5] = '{0, 32'h00, 1, 0, 3, 1, 1, 32'h04, mk_inst(32'h04)};
      tbl[6] = '{0, 32'h00, 1, 0, 2, 1, 1, 32'h08, mk_inst(32'h08)};
      tbl[7] = '{0, 32'h00, 1, 0, 1, 1, 1, 32'h0C, mk_inst(32'h0C)};
      tbl[8] = '{0, 32'h00, 1, 0, 0, 0, 1, 32'h00, NOPV};

      drive(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_inst", out_inst, NOPV);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_taken", 32'(out_taken), 32'd0);

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].v, tbl[i].pc, tbl[i].rdy, tbl[i].fl);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
         chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].opc);
         chk($sformatf("tbl%0d_out_inst", i), out_inst, tbl[i].oinst);
      end

      // steady push+pop at count=2, pointers wrap several times
      step(1, 32'h100, 0, 0);
      step(1, 32'h104, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 32'h200 + 32'(4 * i), 1, 0);
         chk("wrap_count", 32'(count), 32'd2);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

      // flush beats a simultaneous push
      step(1, 32'h300, 0, 0);
      step(1, 32'h304, 0, 0);
      step(1, 32'h308, 0, 0);
      chk("preflush_count", 32'(count), 32'd3);
      step(1, 32'h40, 0, 1);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

      // asynchronous reset between edges
      step(1, 32'h400, 0, 0);
      step(1, 32'h404, 0, 0);
      step(1, 32'h408, 0, 0);
      drive(0, 0, 0, 0);
      chk("premrst_count", 32'(count), 32'd3);
      #2 rst = 1'b0;
      #1;
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_out_inst", out_inst, NOPV);
      q.delete();
      #1 rst = 1'b1;
      drive(1, 32'h500, 0, 0);
      check_model();
      tick();
      chk("postrst_count", 32'(count), 32'd1);
      chk("postrst_out_pc", out_pc, 32'h500);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 7,
              $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 19) == 0);
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0);
      check_model();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the instruction-fetch stage and the decode stage of the pipelined core. Each fetched instruction is captured with its PC and the predictor's taken bit, and entries are released to decode in order. Backpressure from decode (hazard stalls) is absorbed without freezing fetch until the queue fills. A mispredict flush from execute discards every queued entry in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- XLEN, 32: PC and instruction width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- in_valid  in  1  fetch presents an entry this cycle.
- in_pc  in  XLEN  PC of the fetched instruction.
- in_inst  in  XLEN  instruction word from instruction memory.
- in_taken  in  1  predictor taken bit for this PC.
- in_ready  out  1  queue can accept; fetch drives it into its PC write enable.
- out_valid  out  1  head entry is valid.
- out_pc  out  XLEN  head PC.
- out_inst  out  XLEN  head instruction; NOP (0x00000013) when out_valid=0.
- out_taken  out  1  head taken bit; 0 when out_valid=0.
- out_ready  in  1  decode consumes the head this cycle; low during a hazard stall.
- flush  in  1  mispredict or redirect from execute; empties the queue.
- count  out  log2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular buffer of DEPTH entries {pc, inst, taken}, with a read pointer, a write pointer and an occupancy counter.
- Push when in_valid && in_ready. The entry is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop when out_valid && out_ready. The read pointer increments modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state; there is no push-on-full even if a pop happens in the same cycle.
- out_valid = (count != 0). There is no bypass: an entry pushed into an empty queue becomes visible on the next cycle.
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop. count never exceeds DEPTH and never underflows.
- When out_valid=0, outputs are forced as follows: out_inst = NOP, out_pc = 0, out_taken = 0.
- Flush has priority over everything else. Pointers and count go to 0. A push or pop in the same cycle is ignored, so the entry offered alongside the flush is dropped. Fetch re-presents from the redirected PC.
- in_valid while in_ready=0 is not an error. The entry is not taken, and fetch must hold its PC.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1, out_inst=0x00000013, out_pc=0, out_taken=0, both pointers=0. Storage contents are don't-care.
- Reset asserted mid-operation clears the queue immediately (asynchronous). The first push is accepted on the first rising edge after rst deasserts.
- Latency: push at edge N makes the entry visible at head after edge N, so it can be consumed in cycle N+1.
- Throughput: 1 push and 1 pop per cycle in steady state when 0 < count < DEPTH.
- Flush at edge N: out_valid=0 and in_ready=1 after edge N.
- Outputs are driven from registered state plus the read mux only. There is no combinational path from in_* to out_*, or from out_ready to in_ready.

## Structure
- Shared core package holds XLEN, the NOP encoding 0x00000013, and the fetch-entry struct {pc, inst, taken}. Decode and the IF/ID path reuse these.
- Single module with no sub-module. Storage is a register array indexed by the pointers; a separate RAM wrapper is not justified at this depth.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release -> count=0, out_valid=0, in_ready=1, out_inst=0x00000013.
- Fill: push PCs 0x00, 0x04, 0x08, 0x0C with out_ready=0 -> count=4, in_ready=0. A fifth push of 0x10 is refused and count stays 4.
- Drain in order: from full, set out_ready=1 and in_valid=0 -> out_pc reads 0x00, 0x04, 0x08, 0x0C on consecutive cycles, then out_valid=0 and out_inst=NOP.
- Wrap and concurrency: run 10 cycles with push and pop both active at count=2 -> count stays 2, pointers wrap past DEPTH, and order is preserved.
- Flush: with count=3, assert flush together with a push of 0x40 -> next cycle count=0, out_valid=0, and 0x40 is never output.
- Reset mid-operation: with count=3, pulse rst low between edges -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
